// File: rtl/uparc_hilo_ctl_pkg.sv
// HI/LO unit constants: op codes, sequencer states and the default register width.
// `UPARC_REG_WIDTH may be predefined by the build; it falls back to 32 here.
`ifndef UPARC_REG_WIDTH
`define UPARC_REG_WIDTH 32
`endif

package uparc_hilo_ctl_pkg;

  localparam logic [3:0] HILO_OP_NOP   = 4'd0;
  localparam logic [3:0] HILO_OP_MULT  = 4'd1;
  localparam logic [3:0] HILO_OP_MULTU = 4'd2;
  localparam logic [3:0] HILO_OP_MTHI  = 4'd3;
  localparam logic [3:0] HILO_OP_MTLO  = 4'd4;
  localparam logic [3:0] HILO_OP_MFHI  = 4'd5;
  localparam logic [3:0] HILO_OP_MFLO  = 4'd6;
  localparam logic [3:0] HILO_OP_MADD  = 4'd7;
  localparam logic [3:0] HILO_OP_MADDU = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } hilo_state_t;

endpackage

// File: rtl/uparc_hilo_ctl_if.sv
// Execute-stage request bus into the HI/LO unit; busy holds the op in the pipeline.
interface uparc_hilo_ctl_if #(
  parameter int REG_W = `UPARC_REG_WIDTH
) ();

  logic             op_valid;
  logic [3:0]       op;
  logic [REG_W-1:0] rs_data;
  logic [REG_W-1:0] rt_data;
  logic             busy;
  logic [REG_W-1:0] rd_data;

  modport master (
    output op_valid, op, rs_data, rt_data,
    input  busy, rd_data
  );

  modport slave (
    input  op_valid, op, rs_data, rt_data,
    output busy, rd_data
  );

endinterface

// File: rtl/uparc_hilo_ctl.sv
// HI/LO registers and sequencer for the external multi-cycle multiplier.
// Optional UPARC_HILO_MADD_EN adds MADD/MADDU accumulate into {hi,lo}.
module uparc_hilo_ctl
  import uparc_hilo_ctl_pkg::*;
#(
  parameter int REG_W = `UPARC_REG_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  uparc_hilo_ctl_if.slave    ex,
  output logic [REG_W-1:0]   mul_multiplicand,
  output logic [REG_W-1:0]   mul_multiplier,
  output logic               mul_signd,
  output logic               mul_start,
  input  logic               mul_ready,
  input  logic [2*REG_W-1:0] mul_product,
  output logic [REG_W-1:0]   hi,
  output logic [REG_W-1:0]   lo
);

  hilo_state_t state;
  logic        accept;
`ifdef UPARC_HILO_MADD_EN
  logic        acc_mode;
`endif

  assign ex.busy = (state != ST_IDLE);
  assign accept  = ex.op_valid && !ex.busy;

  always_comb begin
    ex.rd_data = '0;
    if (accept) begin
      if (ex.op == HILO_OP_MFHI)
        ex.rd_data = hi;
      else if (ex.op == HILO_OP_MFLO)
        ex.rd_data = lo;
    end
  end

  // Operands stay frozen from START until the product is written back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      hi               <= '0;
      lo               <= '0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      mul_signd        <= 1'b0;
      mul_start        <= 1'b0;
`ifdef UPARC_HILO_MADD_EN
      acc_mode         <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (ex.op)
              HILO_OP_MTHI: hi <= ex.rs_data;
              HILO_OP_MTLO: lo <= ex.rs_data;
              HILO_OP_MULT, HILO_OP_MULTU: begin
                mul_multiplicand <= ex.rs_data;
                mul_multiplier   <= ex.rt_data;
                mul_signd        <= (ex.op == HILO_OP_MULT);
                mul_start        <= 1'b1;
                state            <= ST_START;
`ifdef UPARC_HILO_MADD_EN
                acc_mode         <= 1'b0;
`endif
              end
`ifdef UPARC_HILO_MADD_EN
              HILO_OP_MADD, HILO_OP_MADDU: begin
                mul_multiplicand <= ex.rs_data;
                mul_multiplier   <= ex.rt_data;
                mul_signd        <= (ex.op == HILO_OP_MADD);
                mul_start        <= 1'b1;
                acc_mode         <= 1'b1;
                state            <= ST_START;
              end
`endif
              default: ;
            endcase
          end
        end
        ST_START: begin
          mul_start <= 1'b0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mul_ready) begin
`ifdef UPARC_HILO_MADD_EN
            if (acc_mode)
              {hi, lo} <= {hi, lo} + mul_product;
            else
              {hi, lo} <= mul_product;
`else
            {hi, lo} <= mul_product;
`endif
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uparc_hilo_ctl.sv
// Scoreboard bench for uparc_hilo_ctl with a behavioural multi-cycle multiplier.
module tb_uparc_hilo_ctl;
  import uparc_hilo_ctl_pkg::*;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   mul_multiplicand, mul_multiplier, hi, lo;
  logic           mul_signd, mul_start, mul_ready;
  logic [2*W-1:0] mul_product;

  int n_cmp  = 0;
  int n_bad  = 0;
  int nstart = 0;
  int mcnt;

  logic [W-1:0]   sb_rd[$];
  logic [2*W-1:0] sb_hl[$];
  logic [W-1:0]   m_hi, m_lo;

  always #5 clk = ~clk;

  uparc_hilo_ctl_if #(.REG_W(W)) ex();

  uparc_hilo_ctl #(.REG_W(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .ex               (ex),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_signd        (mul_signd),
    .mul_start        (mul_start),
    .mul_ready        (mul_ready),
    .mul_product      (mul_product),
    .hi               (hi),
    .lo               (lo)
  );

  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax, bx;
    ax = s ? {{32{a[31]}}, a} : {32'b0, a};
    bx = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ax * bx;
  endfunction

  // Multiplier: ready one cycle after start for a zero operand, else 33 cycles after start.
  assign mul_product = ref_mul(mul_signd, mul_multiplicand, mul_multiplier);

  always @(posedge clk) begin
    if (rst) begin
      mcnt      <= 0;
      mul_ready <= 1'b0;
    end else begin
      mul_ready <= 1'b0;
      if (mul_start) begin
        nstart = nstart + 1;
        if (mul_multiplicand == 0 || mul_multiplier == 0) mul_ready <= 1'b1;
        else mcnt <= 32;
      end else if (mcnt > 1) begin
        mcnt <= mcnt - 1;
      end else if (mcnt == 1) begin
        mul_ready <= 1'b1;
        mcnt      <= 0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts and ends one cycle phase after a posedge; held = cycles spent waiting on busy.
  task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, output int held);
    ex.op_valid = 1'b1;
    ex.op       = o;
    ex.rs_data  = a;
    ex.rt_data  = b;
    held = 0;
    @(negedge clk);
    while (ex.busy && held < 200) begin
      held++;
      @(negedge clk);
    end
    if (held >= 200) check("hold_timeout", 1, 0);
    if (o == HILO_OP_MFHI || o == HILO_OP_MFLO) begin
      if (sb_rd.size() == 0) check("rd_queue_empty", 1, 0);
      else check("rd_data", {32'b0, ex.rd_data}, {32'b0, sb_rd.pop_front()});
    end else begin
      check("rd_zero", {32'b0, ex.rd_data}, 64'd0);
    end
    @(posedge clk);
    #1;
    ex.op_valid = 1'b0;
    ex.op       = HILO_OP_NOP;
    ex.rs_data  = '0;
    ex.rt_data  = '0;
  endtask

  task automatic issue_mul(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic s, acc;
    logic [63:0] p;
    int held;
    s   = (o == HILO_OP_MULT) || (o == HILO_OP_MADD);
    acc = (o == HILO_OP_MADD) || (o == HILO_OP_MADDU);
    p   = ref_mul(s, a, b);
    if (acc) {m_hi, m_lo} = {m_hi, m_lo} + p;
    else     {m_hi, m_lo} = p;
    sb_hl.push_back({m_hi, m_lo});
    send(o, a, b, held);
    check("signd", {63'b0, mul_signd}, {63'b0, s});
  endtask

  task automatic finish_mul(input string tag, input int exp_busy, input int start0);
    int n;
    n = 0;
    @(negedge clk);
    while (ex.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy"}, n, exp_busy);
    check({tag, "_start"}, nstart - start0, 1);
    if (sb_hl.size() == 0) check({tag, "_queue_empty"}, 1, 0);
    else check({tag, "_hilo"}, {hi, lo}, sb_hl.pop_front());
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, held;
    rst         = 1'b1;
    ex.op_valid = 1'b0;
    ex.op       = HILO_OP_NOP;
    ex.rs_data  = '0;
    ex.rt_data  = '0;
    m_hi = '0;
    m_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_hi", {32'b0, hi}, 0);
    check("rst_lo", {32'b0, lo}, 0);
    check("rst_busy", {63'b0, ex.busy}, 0);
    check("rst_start", {63'b0, mul_start}, 0);
    check("rst_ops", {mul_multiplicand, mul_multiplier}, 0);
    check("rst_rd", {32'b0, ex.rd_data}, 0);

    s0 = nstart;
    issue_mul(HILO_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_mul("multu_max", 34, s0);
    check("multu_max_lit", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    s0 = nstart;
    issue_mul(HILO_OP_MULT, 32'hFFFF_FFFD, 32'd7);
    finish_mul("mult_neg", 34, s0);
    check("mult_neg_lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    s0 = nstart;
    issue_mul(HILO_OP_MULT, 32'd0, 32'h1234);
    finish_mul("mult_zero", 2, s0);
    check("mult_zero_lit", {hi, lo}, 64'd0);

    // MFLO presented while the multiply is running must wait for the new LO.
    s0 = nstart;
    issue_mul(HILO_OP_MULTU, 32'd5, 32'd6);
    sb_rd.push_back(m_lo);
    send(HILO_OP_MFLO, 32'd0, 32'd0, held);
    check("mflo_held_cycles", held, 34);
    check("mflo_mul_start", nstart - s0, 1);
    check("mflo_mul_hilo", {hi, lo}, sb_hl.pop_front());
    check("mflo_lit_lo", {32'b0, lo}, 64'h1E);

    m_hi = 32'h1234_5678;
    send(HILO_OP_MTHI, 32'h1234_5678, 32'd0, held);
    sb_rd.push_back(m_hi);
    send(HILO_OP_MFHI, 32'd0, 32'd0, held);
    check("mthi_lo_keep", {32'b0, lo}, {32'b0, m_lo});

    send(4'd15, 32'hDEAD_BEEF, 32'd1, held);
    check("nop15_busy", {63'b0, ex.busy}, 0);
    check("nop15_hilo", {hi, lo}, {m_hi, m_lo});

    // Reset in WAIT abandons the multiply.
    send(HILO_OP_MULTU, 32'h0001_0000, 32'h0001_0000, held);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    m_hi = '0;
    m_lo = '0;
    s0   = nstart;
    check("abort_hilo", {hi, lo}, 0);
    check("abort_busy", {63'b0, ex.busy}, 0);
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_start", nstart - s0, 0);
    check("abort_hilo_late", {hi, lo}, 0);

    s0 = nstart;
    issue_mul(HILO_OP_MULTU, 32'd2, 32'd3);
    finish_mul("post_rst", 34, s0);
    check("post_rst_lit", {hi, lo}, 64'd6);

`ifdef UPARC_HILO_MADD_EN
    m_lo = 32'd1;
    send(HILO_OP_MTLO, 32'd1, 32'd0, held);
    m_hi = 32'd0;
    send(HILO_OP_MTHI, 32'd0, 32'd0, held);
    s0 = nstart;
    issue_mul(HILO_OP_MADDU, 32'd2, 32'd3);
    finish_mul("maddu", 34, s0);
    check("maddu_lit", {hi, lo}, 64'd7);
    s0 = nstart;
    issue_mul(HILO_OP_MADD, 32'hFFFF_FFFF, 32'd1);
    finish_mul("madd_wrap", 34, s0);
    check("madd_wrap_lit", {hi, lo}, 64'd6);
`else
    s0 = nstart;
    send(HILO_OP_MADDU, 32'd2, 32'd3, held);
    check("maddu_nop_busy", {63'b0, ex.busy}, 0);
    send(HILO_OP_MADD, 32'd2, 32'd3, held);
    check("madd_nop_busy", {63'b0, ex.busy}, 0);
    repeat (3) @(posedge clk);
    #1;
    check("madd_nop_start", nstart - s0, 0);
    check("madd_nop_hilo", {hi, lo}, 64'd6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
